// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file initiator and its host-side users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  // Defaults shared with the register file; the initiator's WIDTH/ADDR start from these.
  localparam int unsigned RF_WIDTH = 32;
  localparam int unsigned RF_ADDR  = 4;

  // Initiator FSM states, in transaction order.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_e;

  // One host request as carried on the request channel.
  typedef struct packed {
    logic                write;
    logic [RF_ADDR-1:0]  addr;
    logic [RF_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/regfile_initiator.sv
// Purpose: turns valid/ready register requests into WrEn/RdEn slave cycles and returns one response each.
// Latency: rsp_valid rises 2 cycles after the accept cycle for writes, 3 cycles for reads.
// Backpressure: one transaction in flight; req_ready low until the response handshakes, response held stable.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake; req_write/req_addr/req_wdata payload
//   rsp_valid/rsp_ready               response handshake; rsp_write/rsp_rdata payload
//   WrEn/RdEn/Address/WrData/RdData   register-file slave interface (RdData valid the cycle after RdEn)
//   wr_count/rd_count                 saturating counts of completed writes/reads
module regfile_initiator
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = RF_WIDTH,
  parameter int unsigned ADDR  = RF_ADDR,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [ADDR-1:0]  req_addr,
  input  logic [WIDTH-1:0] req_wdata,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [WIDTH-1:0] rsp_rdata,

  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  input  logic [WIDTH-1:0] RdData,

  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);

  state_e             state_q;
  logic               req_ready_q;
  logic               wr_en_q;
  logic               rd_en_q;
  logic [ADDR-1:0]    addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic               rsp_valid_q;
  logic               rsp_write_q;
  logic [WIDTH-1:0]   rsp_rdata_q;
  logic [CNT_W-1:0]   wr_cnt_q;
  logic [CNT_W-1:0]   wr_cnt_d;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic [CNT_W-1:0]   rd_cnt_d;

  logic               req_hs;
  logic               rsp_hs;

  // rsp_valid_q is only ever high in RESP, so the handshake alone marks completion.
  assign req_hs = req_valid & req_ready_q;
  assign rsp_hs = rsp_valid_q & rsp_ready;

  // Saturating completion counters: hold at all-ones rather than wrapping to 0.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (rsp_hs && rsp_write_q && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (rsp_hs && !rsp_write_q && (rd_cnt_q != '1)) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  // Single FSM with registered outputs. WrEn/RdEn are set only on the edge that
  // enters WRITE/READ and default low otherwise, so each is a one-cycle pulse and
  // the two can never overlap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;

      case (state_q)
        IDLE: begin
          if (req_hs) begin
            // Address/WrData are the slave-facing copies of the request; they
            // stay put until the next accept.
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (req_write) begin
              state_q <= WRITE;
              wr_en_q <= 1'b1;
            end else begin
              state_q <= READ;
              rd_en_q <= 1'b1;
            end
          end
        end

        WRITE: begin
          // Slave commits the write on this edge; nothing to read back.
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_write_q <= 1'b1;
          rsp_rdata_q <= '0;
        end

        READ: begin
          // Slave loads RdData on this edge; it becomes usable in CAPTURE.
          state_q <= CAPTURE;
        end

        CAPTURE: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_write_q <= 1'b0;
          rsp_rdata_q <= RdData;
        end

        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wdata_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;

endmodule

// File: doc/regfile_initiator.md
Name: regfile_initiator

Overview:
- Bus initiator that drives the register-file slave interface (WrEn, RdEn, Address, WrData, RdData) from a valid/ready request channel.
- Returns one response per request on a valid/ready response channel.
- Sits between a host-side command source (CPU bridge or test sequencer) and the register file.
- Guarantees the slave never sees WrEn and RdEn asserted together, and handles the one-cycle RdData latency.

Parameters:
- WIDTH, 32, data width; matches the register file.
- ADDR, 4, address width; matches the register file.
- CNT_W, 16, width of the saturating transaction counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR  target register.
- req_wdata  in  WIDTH  write data, ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed this cycle when rsp_valid is also high.
- rsp_write  out  1  echo of the request type.
- rsp_rdata  out  WIDTH  read data; 0 for writes.
- WrEn  out  1  slave write enable.
- RdEn  out  1  slave read enable.
- Address  out  ADDR  slave address.
- WrData  out  WIDTH  slave write data.
- RdData  in  WIDTH  slave read data, valid the cycle after RdEn.
- wr_count  out  CNT_W  completed writes, saturating.
- rd_count  out  CNT_W  completed reads, saturating.

Behaviour:
- All outputs are registered.
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - WrEn, RdEn, Address, WrData, rsp_valid, rsp_write, rsp_rdata, wr_count and rd_count all go to 0.
  - req_ready goes to 1 once rst is released.
- FSM states: IDLE, WRITE, READ, CAPTURE, RESP.
  - IDLE: req_ready=1. On req_valid, latch addr/wdata/write. Next state is WRITE if write, else READ. Address and WrData are registered on the same edge.
  - WRITE: WrEn=1 for exactly one cycle; slave writes at the end of this cycle. Next state RESP with rsp_write=1, rsp_rdata=0, rsp_valid=1.
  - READ: RdEn=1 for exactly one cycle; slave updates RdData at the end of this cycle. Next state CAPTURE.
  - CAPTURE: WrEn=RdEn=0. Register RdData into rsp_rdata. Next state RESP with rsp_write=0, rsp_valid=1.
  - RESP: hold rsp_valid and payload stable until rsp_ready. On the handshake edge: clear rsp_valid, go to IDLE, and increment wr_count or rd_count (saturate at all-ones, no wrap).
- req_ready=0 in every state except IDLE, so there is exactly one outstanding transaction.
- Address and WrData stay unchanged from acceptance until the next acceptance.
- Latency from the request-accept edge to rsp_valid high:
  - write: 2 cycles.
  - read: 3 cycles.
- Throughput with rsp_ready tied high: one write per 3 cycles, one read per 4 cycles.
- WrEn and RdEn are mutually exclusive in every cycle (invariant, asserted in the bench).
- A request arriving while busy is not accepted; the source must hold it (standard valid/ready).
- Reset mid-operation aborts the in-flight transaction: no response is issued and counters return to 0.
- If reset lands in WRITE, the slave is also reset, so no partial state persists.

Decomposition:
- Shared package regfile_pkg holds:
  - the state enum (IDLE, WRITE, READ, CAPTURE, RESP);
  - default WIDTH/ADDR constants shared with the register file;
  - a request struct typedef {write, addr, wdata}.
- No sub-module; a single FSM plus datapath registers.
- The saturating counter is written inline twice.

Test Plan:
- After reset: req_ready=1, WrEn=RdEn=0, rsp_valid=0, counters=0. Asserting rst low mid-READ returns all of these values within the same cycle.
- Write 0xDEADBEEF to addr 3, rsp_ready=1:
  - WrEn high for one cycle with Address=3, WrData=0xDEADBEEF;
  - rsp_valid two cycles after accept with rsp_write=1, rsp_rdata=0;
  - wr_count=1.
- Read addr 3 after that write: RdEn pulses for one cycle, rsp_valid three cycles after accept, rsp_rdata=0xDEADBEEF, rd_count=1.
- Back-to-back requests with req_valid held (write addr 5 = 0x12345678, then read addr 5): the second request is accepted only after the first response handshake, and the read returns 0x12345678.
- Backpressure: rsp_ready=0 for 5 cycles after read rsp_valid. The response payload stays stable, req_ready=0 throughout, and the next request is accepted one cycle after rsp_ready=1.
- Counter saturation with CNT_W=2: five writes leave wr_count=3, and the 0-15 address sweep reads back exactly the written values.
